// File: rtl/bram_block_initiator_pkg.sv
// Shared definitions for the BRAM block-transfer initiator: transfer direction codes
// and the FSM state encoding.
package bram_block_initiator_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StXfer,
        StDone
    } state_e;

endpackage

// File: rtl/line_buffer_ram.sv
// Line buffer: one synchronous write port, two combinational read ports
// (cache-side read and memory write-data path).
module line_buffer_ram #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic [AddrWidth-1:0] raddr_b_i,
    output logic [DataWidth-1:0] rdata_b_o
);

    localparam int unsigned Depth = 1 << AddrWidth;

    // Contents are deliberately not reset.
    logic [DataWidth-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/bram_block_initiator.sv
// Cache-side master for BRAM block transfers: accepts a fill/writeback command, runs the
// req/rw/addr handshake and streams one block through the local line buffer.
module bram_block_initiator
    import bram_block_initiator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned ADDR_WIDTH         = 16,
    parameter int unsigned BLOCK_OFFSET_WIDTH = 5,
    parameter int unsigned TIMEOUT            = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_rw,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr,
    output logic                          done,
    output logic                          err,
    input  logic                          buf_we,
    input  logic [BLOCK_OFFSET_WIDTH-1:0] buf_waddr,
    input  logic [DATA_WIDTH-1:0]         buf_wdata,
    input  logic [BLOCK_OFFSET_WIDTH-1:0] buf_raddr,
    output logic [DATA_WIDTH-1:0]         buf_rdata,
    output logic                          mem_req,
    output logic                          mem_rw,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic                          mem_wreq,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic                          mem_rvalid,
    input  logic                          mem_finished
);

    localparam int unsigned BOW    = BLOCK_OFFSET_WIDTH;
    localparam int unsigned TcntW  = $clog2(TIMEOUT) + 1;
    localparam logic [BOW:0]       BlockSize = {1'b1, {BOW{1'b0}}};
    localparam logic [TcntW-1:0]   TcntLast  = TcntW'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BOW-1:0]        wptr_q, wptr_d;
    logic [BOW:0]          rcnt_q, rcnt_d;
    logic [TcntW-1:0]      tcnt_q, tcnt_d;
    logic                  err_q, err_d;

    logic                  ram_we;
    logic [BOW-1:0]        ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [BOW-1:0]        ram_mem_raddr;

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wptr_d    = wptr_q;
        rcnt_d    = rcnt_q;
        tcnt_d    = tcnt_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_waddr = buf_waddr;
        ram_wdata = buf_wdata;

        unique case (state_q)
            StIdle: begin
                ram_we = buf_we;
                if (cmd_valid) begin
                    rw_d    = cmd_rw;
                    addr_d  = {cmd_addr[ADDR_WIDTH-1:BOW], {BOW{1'b0}}};
                    wptr_d  = '0;
                    rcnt_d  = '0;
                    tcnt_d  = '0;
                    err_d   = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StXfer;
            end
            StXfer: begin
                tcnt_d = tcnt_q + 1'b1;
                if (rw_q == MEM_READ && mem_rvalid) begin
                    if (rcnt_q < BlockSize) begin
                        ram_we    = 1'b1;
                        ram_waddr = rcnt_q[BOW-1:0];
                        ram_wdata = mem_rdata;
                        rcnt_d    = rcnt_q + 1'b1;
                    end else begin
                        // Overlong burst: drop the beat, flag the transfer.
                        err_d = 1'b1;
                    end
                end
                if (rw_q == MEM_WRITE && mem_wreq) begin
                    wptr_d = wptr_q + 1'b1;
                end
                if (mem_finished) begin
                    state_d = StDone;
                    rw_d    = 1'b0;
                    addr_d  = '0;
                    if (rw_q == MEM_READ && rcnt_d != BlockSize) begin
                        err_d = 1'b1;
                    end
                end else if (tcnt_d == TcntLast) begin
                    state_d = StDone;
                    rw_d    = 1'b0;
                    addr_d  = '0;
                    err_d   = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wptr_q  <= '0;
            rcnt_q  <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wptr_q  <= wptr_d;
            rcnt_q  <= rcnt_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
        end
    end

    // Look one word ahead while the controller is consuming write data.
    assign ram_mem_raddr = wptr_q + BOW'(mem_wreq);

    assign cmd_ready = (state_q == StIdle);
    assign mem_req   = (state_q == StReq);
    assign done      = (state_q == StDone);
    assign err       = (state_q == StDone) && err_q;
    assign mem_rw    = rw_q;
    assign mem_addr  = addr_q;

    line_buffer_ram #(
        .DataWidth(DATA_WIDTH),
        .AddrWidth(BOW)
    ) u_line_buffer_ram (
        .clk_i    (clk),
        .we_i     (ram_we),
        .waddr_i  (ram_waddr),
        .wdata_i  (ram_wdata),
        .raddr_a_i(buf_raddr),
        .rdata_a_o(buf_rdata),
        .raddr_b_i(ram_mem_raddr),
        .rdata_b_o(mem_wdata)
    );

endmodule
